// File: rtl/truth_table_lut.sv
// ----------------------------------------------------------------------------
// truth_table_lut
//
// Purpose:
//   Programmable N_IN-input boolean function. One 2^N_IN-bit truth table
//   is active at a time, and it evaluates one request per cycle with a
//   registered result one cycle later. A new table is shifted in serially,
//   LSB first, into a shadow register. It reaches the active table in one
//   step only once every bit has arrived, so a partial or aborted load never
//   disturbs evaluation.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in           logic inputs, i_in[0] is the table index LSB
//   i_in_valid     evaluation request
//   o_in_ready     high in RUN; request accepted when i_in_valid && o_in_ready
//   o_out          registered evaluation result, held between evaluations
//   o_out_valid    one-cycle pulse marking a new o_out
//   o_out_changed  one-cycle pulse with o_out_valid when o_out changed value
//   i_cfg_start    begin (or restart) a serial table load
//   i_cfg_valid    i_cfg_bit is valid this cycle
//   i_cfg_bit      table bit, index 0 first
//   i_cfg_abort    discard the load in progress
//   o_cfg_busy     high while a load is in progress
//   o_cfg_done     one-cycle pulse after the new table is committed
// ----------------------------------------------------------------------------
module truth_table_lut #(
    parameter int                        N_IN          = 2,
    parameter logic [(2**N_IN)-1:0]      DEFAULT_TABLE = 4'b0100
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_IN-1:0] i_in,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic            o_out,
    output logic            o_out_valid,
    output logic            o_out_changed,
    input  logic            i_cfg_start,
    input  logic            i_cfg_valid,
    input  logic            i_cfg_bit,
    input  logic            i_cfg_abort,
    output logic            o_cfg_busy,
    output logic            o_cfg_done
);

    localparam int              TBL_W    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]       r_state;
    logic [N_IN-1:0]  r_count;
    logic [TBL_W-1:0] r_shadow;
    logic [TBL_W-1:0] r_active;
    logic             r_out;
    logic             r_out_valid;
    logic             r_out_changed;
    logic             r_cfg_done;

    logic [0:0]       w_state_d;
    logic [N_IN-1:0]  w_count_d;
    logic [TBL_W-1:0] w_shadow_d;
    logic [TBL_W-1:0] w_active_d;
    logic             w_done_d;
    logic [TBL_W-1:0] w_shadow_wr;
    logic             w_accept;
    logic             w_eval;

    // Shadow with the current bit inserted. The final bit is committed from
    // here so the active table is complete on the same edge.
    always_comb begin
        w_shadow_wr          = r_shadow;
        w_shadow_wr[r_count] = i_cfg_bit;
    end

    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_shadow_d = r_shadow;
        w_active_d = r_active;
        w_done_d   = 1'b0;
        case (r_state)
            ST_RUN: begin
                // cfg_valid/cfg_bit/cfg_abort are deliberately ignored here.
                if (i_cfg_start) begin
                    w_state_d  = ST_LOAD;
                    w_count_d  = '0;
                    w_shadow_d = '0;
                end
            end
            ST_LOAD: begin
                // Abort wins over restart and over a final bit.
                if (i_cfg_abort) begin
                    w_state_d = ST_RUN;
                    w_count_d = '0;
                end else if (i_cfg_start) begin
                    w_count_d  = '0;
                    w_shadow_d = '0;
                end else if (i_cfg_valid) begin
                    w_shadow_d = w_shadow_wr;
                    if (r_count == LAST_IDX) begin
                        w_active_d = w_shadow_wr;
                        w_done_d   = 1'b1;
                        w_state_d  = ST_RUN;
                        w_count_d  = '0;
                    end else begin
                        w_count_d = r_count + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_RUN;
                w_count_d = '0;
            end
        endcase
    end

    // Acceptance depends on the current state only, so an evaluation in the
    // same cycle as cfg_start still completes against the old table.
    assign w_accept = i_in_valid && (r_state == ST_RUN);
    assign w_eval   = r_active[i_in];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_count       <= '0;
            r_shadow      <= '0;
            r_active      <= DEFAULT_TABLE;
            r_out         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_changed <= 1'b0;
            r_cfg_done    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_count       <= w_count_d;
            r_shadow      <= w_shadow_d;
            r_active      <= w_active_d;
            r_cfg_done    <= w_done_d;
            r_out_valid   <= w_accept;
            r_out_changed <= w_accept && (w_eval != r_out);
            if (w_accept) begin
                r_out <= w_eval;
            end
        end
    end

    assign o_in_ready    = (r_state == ST_RUN);
    assign o_cfg_busy    = (r_state == ST_LOAD);
    assign o_out         = r_out;
    assign o_out_valid   = r_out_valid;
    assign o_out_changed = r_out_changed;
    assign o_cfg_done    = r_cfg_done;

endmodule

// File: doc/truth_table_lut.md
TRUTH_TABLE_LUT -- requirements
Module: truth_table_lut

Interface
REQ-001 The module SHALL have parameter N_IN, default 2, giving the number of logic inputs (legal range 1..6).
REQ-002 The module SHALL have parameter DEFAULT_TABLE, default 4'b0100, giving the 2^N_IN-bit truth table active after reset; bit k is the output for input index k.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  N_IN  logic inputs; in[0] is the index LSB.
REQ-006 in_valid  input  1  request to evaluate `in`.
REQ-007 in_ready  output  1  evaluation accepted this cycle when in_valid=1.
REQ-008 out  output  1  registered evaluation result, held between evaluations.
REQ-009 out_valid  output  1  one-cycle pulse marking a new `out`.
REQ-010 out_changed  output  1  one-cycle pulse, coincident with out_valid, when the new `out` differs from the previous `out`.
REQ-011 cfg_start  input  1  begin a serial table load.
REQ-012 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-013 cfg_bit  input  1  table bit, LSB (index 0) first.
REQ-014 cfg_abort  input  1  discard an in-progress load.
REQ-015 cfg_busy  output  1  high while in LOAD.
REQ-016 cfg_done  output  1  one-cycle pulse on table commit.

Function
REQ-017 The FSM SHALL have two states: RUN (evaluate) and LOAD (shift in a new table); reset enters RUN.
REQ-018 In RUN, in_ready SHALL be 1; in LOAD, in_ready SHALL be 0.
REQ-019 An evaluation SHALL be accepted when in_valid && in_ready; one cycle later out = active_table[in], out_valid=1 (latency 1, throughput 1 per cycle).
REQ-020 Without an accepted evaluation, out_valid and out_changed SHALL be 0 and `out` SHALL hold its value.
REQ-021 out_changed SHALL be 1 only in a cycle where out_valid=1 and the new `out` differs from the prior registered `out`.
REQ-022 In RUN, cfg_start=1 SHALL move the FSM to LOAD next cycle and clear the bit counter; an evaluation accepted in the same cycle SHALL still complete normally.
REQ-023 In LOAD, each cycle with cfg_valid=1 SHALL write cfg_bit to shadow[count] and increment count; cycles with cfg_valid=0 SHALL leave the shadow register and count unchanged.
REQ-024 When the bit with count = 2^N_IN-1 is written, the module SHALL copy the full shadow table to active_table, pulse cfg_done next cycle, and return to RUN next cycle.
REQ-025 cfg_abort=1 in LOAD SHALL return the FSM to RUN next cycle with active_table unchanged and no cfg_done pulse; cfg_abort SHALL take priority over a same-cycle final cfg_valid.
REQ-026 cfg_start asserted while in LOAD SHALL restart the load: count cleared, and the partial shadow contents ignored.
REQ-027 cfg_valid, cfg_abort and cfg_bit SHALL be ignored in RUN.
REQ-028 The first evaluation after a commit SHALL use the new table; `out` SHALL be unaffected by the commit itself.

Reset
REQ-029 While rst_n=0, regardless of clk: state=RUN, active_table=DEFAULT_TABLE, shadow=0, count=0, out=0, out_valid=0, out_changed=0, cfg_busy=0, cfg_done=0, in_ready=1 once released.
REQ-030 Reset asserted mid-LOAD SHALL abandon the load and restore DEFAULT_TABLE.
REQ-031 out_changed on the first evaluation after reset SHALL compare against the reset value out=0.

Verification
REQ-032 Reset, N_IN=2, then apply in=0,1,2,3 on consecutive cycles with in_valid=1 -> out=0,0,1,0 one cycle later each; out_valid=1 for 4 cycles; out_changed pulses on index 2 and on index 3.
REQ-033 cfg_start, then bits 1,0,0,0 (table 4'b0001) with gaps where cfg_valid=0 -> cfg_busy=1 throughout, in_ready=0, cfg_done pulses once; then in=0 -> out=1.
REQ-034 Start a load, send 2 bits, cfg_abort -> no cfg_done, back to RUN; in=2 -> out=1 (table unchanged).
REQ-035 cfg_start with in_valid=1 and in=2 in the same cycle -> out=1 and out_valid=1 next cycle, while cfg_busy=1.
REQ-036 Drop rst_n asynchronously mid-load after 3 bits -> outputs clear immediately; after release, in=2 -> out=1 (DEFAULT_TABLE).
REQ-037 N_IN=3 instance: load 8'b10100000, then sweep in=0..7 -> out=1 only for in=5 and in=7.
